// File: rtl/cgra_ctrl_pkg.sv
// Shared types and helpers for the CGRA configuration/execution controller.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package cgra_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_INIT = 3'd1,
        ST_LOAD_CONF = 3'd2,
        ST_RUN       = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    // Integer ceiling division, used to size the per-word beat count.
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/conf_ram_2p.sv
// Simple dual-port configuration RAM: one write port, one registered read port.
// Latency: read data appears one cycle after re_i; dout_o holds between reads.
// Backpressure: none; both ports accept an access every cycle.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset (read register only)
//   we_i/waddr_i/wdata_i write port
//   re_i/raddr_i         read request
//   dout_o               registered read data, 0 after reset
module conf_ram_2p #(
    parameter int CONF_WIDTH = 352,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [CONF_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [CONF_WIDTH-1:0] dout_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Storage is deliberately left out of reset.
    logic [CONF_WIDTH-1:0] mem_q [DEPTH];
    logic [CONF_WIDTH-1:0] dout_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q <= '0;
        end else if (re_i) begin
            dout_q <= mem_q[raddr_i];
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/control_exec_ctx.sv
// Loads an initial-context beat plus num_conf configuration words into RAM, then loops a PC over them.
// Latency: word written 1 cycle after its last beat; conf_out valid 1 cycle after each en_pc fetch.
// Backpressure: req_rd_data qualifies beats; available_read gaps stall loading without loss.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   start, num_conf, start_loop,
//   num_iter                      job launch; parameters sampled with start while idle
//   en_pc                         advance PC / issue one fetch this cycle
//   available_read, rd_data       read-bus beat (accepted when req_rd_data is also high)
//   req_rd_data                   beats wanted
//   conf_out, conf_valid          fetched configuration word and its qualifier
//   initial_conf                  first loaded beat
//   start_unit_exec               level, load finished
//   exec_done                     one-cycle pulse at end of the final pass
//   busy                          job in progress
module control_exec_ctx
    import cgra_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int CONF_WIDTH = 352,
    parameter int ADDR_WIDTH = 10,
    parameter int ITER_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_conf,
    input  logic [ADDR_WIDTH-1:0] start_loop,
    input  logic [ITER_WIDTH-1:0] num_iter,
    input  logic                  en_pc,
    input  logic                  available_read,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  req_rd_data,
    output logic [CONF_WIDTH-1:0] conf_out,
    output logic                  conf_valid,
    output logic [DATA_WIDTH-1:0] initial_conf,
    output logic                  start_unit_exec,
    output logic                  exec_done,
    output logic                  busy
);

    localparam int                BEATS     = ceil_div(CONF_WIDTH, DATA_WIDTH);
    localparam int                BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    state_e                  state_q;
    logic [ADDR_WIDTH:0]     num_conf_q;
    logic [ADDR_WIDTH-1:0]   loop_q;
    logic [ITER_WIDTH-1:0]   num_iter_q;
    logic [ITER_WIDTH-1:0]   pass_q;
    logic [BEAT_W-1:0]       beat_q;
    logic [CONF_WIDTH-1:0]   asm_q;
    logic [CONF_WIDTH-1:0]   asm_d;
    logic [ADDR_WIDTH:0]     rcv_cnt_q;   // words whose last beat has been accepted
    logic [ADDR_WIDTH:0]     wr_cnt_q;    // words written; low bits are the write address
    logic                    wr_pend_q;
    logic [ADDR_WIDTH-1:0]   pc_q;
    logic [ADDR_WIDTH-1:0]   pc_d;
    logic [DATA_WIDTH-1:0]   init_q;
    logic                    sue_q;
    logic                    done_q;
    logic                    busy_q;
    logic                    valid_q;

    logic accept;
    logic beat_last;
    logic last_write;
    logic pc_last;
    logic pass_last;
    logic rd_en;

    // Stop requesting once every word's beats are in, so the final write cycle cannot swallow a beat.
    assign req_rd_data = (state_q == ST_LOAD_INIT) ||
                         ((state_q == ST_LOAD_CONF) && (rcv_cnt_q != num_conf_q));
    assign accept      = req_rd_data && available_read;
    assign beat_last   = (beat_q == LAST_BEAT);
    assign last_write  = wr_pend_q && ((wr_cnt_q + 1'b1) == num_conf_q);
    assign pc_last     = ({1'b0, pc_q} == (num_conf_q - 1'b1));
    assign pass_last   = (num_iter_q != '0) && ((pass_q + 1'b1) == num_iter_q);
    assign rd_en       = (state_q == ST_RUN) && en_pc && (num_conf_q != '0);
    assign pc_d        = rd_en ? (pc_last ? loop_q : pc_q + 1'b1) : pc_q;

    // Drop the current beat into its slice of the word; bits past CONF_WIDTH are discarded.
    always_comb begin
        asm_d = asm_q;
        for (int b = 0; b < CONF_WIDTH; b++) begin
            if ((b / DATA_WIDTH) == int'(beat_q)) begin
                asm_d[b] = rd_data[b % DATA_WIDTH];
            end
        end
    end

    // The assembled word is written the cycle after its last beat. A beat accepted in that same
    // cycle updates asm_q on the same edge the RAM samples the old (complete) value.
    conf_ram_2p #(
        .CONF_WIDTH (CONF_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_pend_q),
        .waddr_i (wr_cnt_q[ADDR_WIDTH-1:0]),
        .wdata_i (asm_q),
        .re_i    (rd_en),
        .raddr_i (pc_q),
        .dout_o  (conf_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            num_conf_q <= '0;
            loop_q     <= '0;
            num_iter_q <= '0;
            pass_q     <= '0;
            beat_q     <= '0;
            asm_q      <= '0;
            rcv_cnt_q  <= '0;
            wr_cnt_q   <= '0;
            wr_pend_q  <= 1'b0;
            pc_q       <= '0;
            init_q     <= '0;
            sue_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            wr_pend_q <= 1'b0;
            valid_q   <= rd_en;

            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        num_conf_q <= num_conf;
                        // An out-of-range re-entry point falls back to the first word.
                        loop_q     <= ({1'b0, start_loop} >= num_conf) ? '0 : start_loop;
                        num_iter_q <= num_iter;
                        pass_q     <= '0;
                        beat_q     <= '0;
                        rcv_cnt_q  <= '0;
                        wr_cnt_q   <= '0;
                        pc_q       <= '0;
                        sue_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_LOAD_INIT;
                    end
                end

                ST_LOAD_INIT: begin
                    if (accept) begin
                        init_q <= rd_data;
                        if (num_conf_q == '0) begin
                            sue_q   <= 1'b1;
                            state_q <= ST_RUN;
                        end else begin
                            state_q <= ST_LOAD_CONF;
                        end
                    end
                end

                ST_LOAD_CONF: begin
                    if (accept) begin
                        asm_q <= asm_d;
                        if (beat_last) begin
                            beat_q    <= '0;
                            rcv_cnt_q <= rcv_cnt_q + 1'b1;
                            wr_pend_q <= 1'b1;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                    if (wr_pend_q) begin
                        wr_cnt_q <= wr_cnt_q + 1'b1;
                        if (last_write) begin
                            sue_q   <= 1'b1;
                            state_q <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    pc_q <= pc_d;
                    if (num_conf_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (rd_en && pc_last) begin
                        pass_q <= pass_q + 1'b1;
                        if (pass_last) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign conf_valid      = valid_q;
    assign initial_conf    = init_q;
    assign start_unit_exec = sue_q;
    assign exec_done       = done_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_control_exec_ctx.sv
module tb_control_exec_ctx;

    localparam int DW  = 512;
    localparam int CWA = 352;
    localparam int AWA = 10;
    localparam int CWB = 600;
    localparam int AWB = 4;
    localparam int IW  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           start;
    logic           en_pc;
    logic           available_read;
    logic [AWA:0]   num_conf;
    logic [AWA-1:0] start_loop;
    logic [IW-1:0]  num_iter;
    logic [DW-1:0]  rd_data;
    logic           use_mb;
    logic           start_a, start_b;

    assign start_a = start && !use_mb;
    assign start_b = start && use_mb;

    logic           req_a, cv_a, sue_a, done_a, busy_a;
    logic [CWA-1:0] conf_a;
    logic [DW-1:0]  init_a;
    logic           req_b, cv_b, sue_b, done_b, busy_b;
    logic [CWB-1:0] conf_b;
    logic [DW-1:0]  init_b;

    control_exec_ctx #(.DATA_WIDTH(DW), .CONF_WIDTH(CWA), .ADDR_WIDTH(AWA), .ITER_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .start(start_a), .num_conf(num_conf), .start_loop(start_loop),
        .num_iter(num_iter), .en_pc(en_pc), .available_read(available_read), .rd_data(rd_data),
        .req_rd_data(req_a), .conf_out(conf_a), .conf_valid(cv_a), .initial_conf(init_a),
        .start_unit_exec(sue_a), .exec_done(done_a), .busy(busy_a));

    control_exec_ctx #(.DATA_WIDTH(DW), .CONF_WIDTH(CWB), .ADDR_WIDTH(AWB), .ITER_WIDTH(IW)) dut_mb (
        .clk(clk), .rst(rst), .start(start_b), .num_conf(num_conf[AWB:0]), .start_loop(start_loop[AWB-1:0]),
        .num_iter(num_iter), .en_pc(en_pc), .available_read(available_read), .rd_data(rd_data),
        .req_rd_data(req_b), .conf_out(conf_b), .conf_valid(cv_b), .initial_conf(init_b),
        .start_unit_exec(sue_b), .exec_done(done_b), .busy(busy_b));

    // Outputs of whichever instance the current test targets.
    logic           req_s, cv_s, sue_s, done_s, busy_s;
    logic [CWB-1:0] conf_s;
    logic [DW-1:0]  init_s;
    assign req_s  = use_mb ? req_b  : req_a;
    assign cv_s   = use_mb ? cv_b   : cv_a;
    assign sue_s  = use_mb ? sue_b  : sue_a;
    assign done_s = use_mb ? done_b : done_a;
    assign busy_s = use_mb ? busy_b : busy_a;
    assign init_s = use_mb ? init_b : init_a;
    assign conf_s = use_mb ? conf_b : {{(CWB - CWA){1'b0}}, conf_a};

    int passed = 0;
    int total  = 0;

    // Reference model: beat stream, resulting words, and expected fetch-address order.
    logic [DW-1:0]  beats[$];
    logic [CWB-1:0] words[$];
    int             addrs[$];
    logic [CWB-1:0] obs[$];

    int load_lat, load_taken, done_cnt, done_at, viol;
    bit load_to;

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] r;
        for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic gen_model(input int n, input int loop, input int iter, input int cw, input int max_len);
        int bpw, eff, p;
        logic [2*DW-1:0] cat;
        beats.delete(); words.delete(); addrs.delete();
        bpw = (cw + DW - 1) / DW;
        for (int i = 0; i < 1 + n * bpw; i++) beats.push_back(rand_beat());
        for (int w = 0; w < n; w++) begin
            cat = '0;
            for (int k = 0; k < bpw; k++) cat[k*DW +: DW] = beats[1 + w * bpw + k];
            for (int b = cw; b < 2 * DW; b++) cat[b] = 1'b0;
            words.push_back(cat[CWB-1:0]);
        end
        // First pass covers every word; later passes restart at the (clamped) loop point.
        eff = (loop >= n) ? 0 : loop;
        p = 0;
        if (n > 0) begin
            while ((iter == 0 || p < iter) && addrs.size() < max_len) begin
                for (int a = (p == 0) ? 0 : eff; a < n; a++)
                    if (addrs.size() < max_len) addrs.push_back(a);
                p++;
            end
        end
    endtask

    task automatic do_load(input int n, input int loop, input int iter, input int gap, input bit mb);
        int idx, since;
        @(negedge clk);
        use_mb = mb; start = 1'b1; num_conf = (AWA + 1)'(n);
        start_loop = AWA'(loop); num_iter = IW'(iter);
        @(negedge clk);
        start = 1'b0;
        idx = 0; since = -1; load_to = 1'b1; load_lat = -1;
        for (int c = 0; c < 5000; c++) begin
            if (since >= 0) since++;
            if (sue_s) begin
                load_lat = since; load_to = 1'b0;
                break;
            end
            available_read = ($urandom_range(0, 99) >= gap);
            rd_data = (idx < beats.size()) ? beats[idx] : rand_beat();
            if (req_s && available_read) begin
                idx++;
                if (idx == beats.size()) since = 0;
            end
            @(negedge clk);
        end
        available_read = 1'b0;
        load_taken = idx;
    endtask

    task automatic do_run(input int cycles, input int en_pct, input int stop_after, input int poke_start);
        bit prev_en;
        int after;
        obs.delete(); done_cnt = 0; done_at = -1; viol = 0; after = -1;
        prev_en = en_pc;
        for (int c = 0; c < cycles; c++) begin
            if (cv_s) obs.push_back(conf_s);
            if (done_cnt == 0 && cv_s !== prev_en) viol++;
            if (done_s) begin
                if (done_cnt == 0) done_at = c;
                done_cnt++;
            end
            if (done_cnt > 0) begin
                after++;
                if (after >= stop_after) break;
            end
            en_pc = ($urandom_range(0, 99) < en_pct);
            prev_en = en_pc;
            start = (c == poke_start);
            if (c == poke_start) begin
                num_conf = 1; start_loop = 0;
            end
            @(negedge clk);
        end
        en_pc = 1'b0; start = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        total++; if ({req_a, cv_a, sue_a, done_a, busy_a} !== 5'b0) begin
            $display("FAIL reset_ctrl_a: got %b want 00000", {req_a, cv_a, sue_a, done_a, busy_a}); end else passed++;
        total++; if (init_a !== '0 || conf_a !== '0) begin
            $display("FAIL reset_data_a: init %h conf %h want 0", init_a, conf_a); end else passed++;
        total++; if ({req_b, cv_b, sue_b, done_b, busy_b} !== 5'b0) begin
            $display("FAIL reset_ctrl_b: got %b want 00000", {req_b, cv_b, sue_b, done_b, busy_b}); end else passed++;
        total++; if (init_b !== '0 || conf_b !== '0) begin
            $display("FAIL reset_data_b: init %h conf %h want 0", init_b, conf_b); end else passed++;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_beat();
        gen_model(4, 1, 2, CWA, 100);
        do_load(4, 1, 2, 40, 1'b0);
        total++; if (load_to || load_lat != 2) begin
            $display("FAIL sb_load_lat: got %0d (timeout %0d) want 2", load_lat, load_to); end else passed++;
        total++; if (load_taken != 5) begin
            $display("FAIL sb_beats_taken: got %0d want 5", load_taken); end else passed++;
        total++; if (init_s !== beats[0]) begin
            $display("FAIL sb_initial_conf: got %h want %h", init_s, beats[0]); end else passed++;
        total++; if (busy_s !== 1'b1) begin
            $display("FAIL sb_busy_run: got %b want 1", busy_s); end else passed++;
        do_run(200, 70, 4, 3);
        total++; if (obs.size() != addrs.size()) begin
            $display("FAIL sb_read_count: got %0d want %0d", obs.size(), addrs.size()); end else passed++;
        for (int i = 0; i < obs.size() && i < addrs.size(); i++) begin
            total++; if (obs[i] !== words[addrs[i]]) begin
                $display("FAIL sb_read%0d: got %h want %h", i, obs[i], words[addrs[i]]); end else passed++;
        end
        total++; if (done_cnt != 1 || viol != 0) begin
            $display("FAIL sb_done_valid: done pulses %0d want 1, valid slips %0d want 0", done_cnt, viol); end else passed++;
        total++; if ({busy_s, sue_s} !== 2'b01) begin
            $display("FAIL sb_after_done: busy,sue %b want 01", {busy_s, sue_s}); end else passed++;
    endtask

    task automatic test_multi_beat();
        gen_model(3, 0, 1, CWB, 100);
        do_load(3, 0, 1, 30, 1'b1);
        total++; if (load_to || load_lat != 2 || load_taken != 7) begin
            $display("FAIL mb_load: lat %0d taken %0d want 2 and 7", load_lat, load_taken); end else passed++;
        total++; if (init_s !== beats[0]) begin
            $display("FAIL mb_initial_conf: got %h want %h", init_s, beats[0]); end else passed++;
        do_run(100, 60, 3, -1);
        total++; if (obs.size() != 3) begin
            $display("FAIL mb_read_count: got %0d want 3", obs.size()); end else passed++;
        if (obs.size() > 0) begin
            total++; if (obs[0] !== {beats[2][87:0], beats[1]}) begin
                $display("FAIL mb_word0: got %h want %h", obs[0], {beats[2][87:0], beats[1]}); end else passed++;
        end
        for (int i = 0; i < obs.size() && i < addrs.size(); i++) begin
            total++; if (obs[i] !== words[addrs[i]]) begin
                $display("FAIL mb_read%0d: got %h want %h", i, obs[i], words[addrs[i]]); end else passed++;
        end
        total++; if (done_cnt != 1) begin
            $display("FAIL mb_done: got %0d pulses want 1", done_cnt); end else passed++;
    endtask

    task automatic test_forever();
        gen_model(3, 2, 0, CWA, 400);
        do_load(3, 2, 0, 20, 1'b0);
        do_run(120, 60, 0, -1);
        total++; if (done_cnt != 0 || viol != 0) begin
            $display("FAIL fv_done_valid: done pulses %0d want 0, valid slips %0d want 0", done_cnt, viol); end else passed++;
        total++; if (obs.size() < 20 || obs.size() > addrs.size()) begin
            $display("FAIL fv_read_count: got %0d want 20..%0d", obs.size(), addrs.size()); end else passed++;
        for (int i = 0; i < obs.size() && i < addrs.size(); i++) begin
            total++; if (obs[i] !== words[addrs[i]]) begin
                $display("FAIL fv_read%0d: got %h want %h", i, obs[i], words[addrs[i]]); end else passed++;
        end
        total++; if ({busy_s, sue_s} !== 2'b11) begin
            $display("FAIL fv_still_running: busy,sue %b want 11", {busy_s, sue_s}); end else passed++;
        apply_reset();
    endtask

    task automatic test_zero_conf();
        gen_model(0, 0, 1, CWA, 10);
        do_load(0, 0, 1, 50, 1'b0);
        total++; if (load_to || load_lat != 1 || load_taken != 1) begin
            $display("FAIL zc_load: lat %0d taken %0d want 1 and 1", load_lat, load_taken); end else passed++;
        total++; if (init_s !== beats[0]) begin
            $display("FAIL zc_initial_conf: got %h want %h", init_s, beats[0]); end else passed++;
        do_run(20, 100, 3, -1);
        total++; if (obs.size() != 0 || done_cnt != 1) begin
            $display("FAIL zc_run: reads %0d done %0d want 0 and 1", obs.size(), done_cnt); end else passed++;
    endtask

    task automatic test_reset_midload();
        int idx;
        gen_model(5, 0, 1, CWA, 100);
        @(negedge clk);
        use_mb = 1'b0; start = 1'b1; num_conf = 5; start_loop = 0; num_iter = 1;
        @(negedge clk);
        start = 1'b0; idx = 0;
        for (int c = 0; c < 50 && idx < 3; c++) begin
            available_read = 1'b1; rd_data = beats[idx];
            if (req_s) idx++;
            @(negedge clk);
        end
        available_read = 1'b0;
        @(negedge clk); @(negedge clk);
        total++; if (busy_s !== 1'b1 || init_s !== beats[0]) begin
            $display("FAIL rm_before: busy %b init %h want 1 %h", busy_s, init_s, beats[0]); end else passed++;
        rst = 1'b0;
        #1;
        total++; if ({req_s, cv_s, sue_s, done_s, busy_s} !== 5'b0 || init_s !== '0 || conf_s !== '0) begin
            $display("FAIL rm_async_clear: ctrl %b init %h conf %h want all 0",
                     {req_s, cv_s, sue_s, done_s, busy_s}, init_s, conf_s); end else passed++;
        @(negedge clk); rst = 1'b1;
        gen_model(2, 1, 1, CWA, 100);
        do_load(2, 1, 1, 30, 1'b0);
        total++; if (load_to || load_lat != 2 || load_taken != 3) begin
            $display("FAIL rm_reload: lat %0d taken %0d want 2 and 3", load_lat, load_taken); end else passed++;
        do_run(60, 80, 3, -1);
        total++; if (obs.size() != 2 || done_cnt != 1) begin
            $display("FAIL rm_run: reads %0d done %0d want 2 and 1", obs.size(), done_cnt); end else passed++;
        for (int i = 0; i < obs.size() && i < addrs.size(); i++) begin
            total++; if (obs[i] !== words[addrs[i]]) begin
                $display("FAIL rm_read%0d: got %h want %h", i, obs[i], words[addrs[i]]); end else passed++;
        end
    endtask

    task automatic test_loop_clamp();
        gen_model(3, 5, 2, CWA, 100);
        do_load(3, 5, 2, 0, 1'b0);
        total++; if (load_to || load_lat != 2 || load_taken != 4) begin
            $display("FAIL lc_load: lat %0d taken %0d want 2 and 4", load_lat, load_taken); end else passed++;
        do_run(100, 75, 3, -1);
        total++; if (obs.size() != 6 || done_cnt != 1) begin
            $display("FAIL lc_run: reads %0d done %0d want 6 and 1", obs.size(), done_cnt); end else passed++;
        for (int i = 0; i < obs.size() && i < addrs.size(); i++) begin
            total++; if (obs[i] !== words[addrs[i]]) begin
                $display("FAIL lc_read%0d: got %h want %h", i, obs[i], words[addrs[i]]); end else passed++;
        end
    endtask

    task automatic test_full_depth();
        gen_model(16, 0, 2, CWB, 100);
        do_load(16, 0, 2, 25, 1'b1);
        total++; if (load_to || load_lat != 2 || load_taken != 33) begin
            $display("FAIL fd_load: lat %0d taken %0d want 2 and 33", load_lat, load_taken); end else passed++;
        do_run(300, 80, 3, -1);
        total++; if (obs.size() != 32 || done_cnt != 1) begin
            $display("FAIL fd_run: reads %0d done %0d want 32 and 1", obs.size(), done_cnt); end else passed++;
        for (int i = 0; i < obs.size() && i < addrs.size(); i++) begin
            total++; if (obs[i] !== words[addrs[i]]) begin
                $display("FAIL fd_read%0d: got %h want %h", i, obs[i], words[addrs[i]]); end else passed++;
        end
    endtask

    task automatic test_back_to_back();
        gen_model(6, 4, 3, CWA, 100);
        do_load(6, 4, 3, 0, 1'b0);
        do_run(100, 100, 3, -1);
        total++; if (done_at != addrs.size() || done_cnt != 1) begin
            $display("FAIL bb_done_time: done at %0d (%0d pulses) want %0d (1)", done_at, done_cnt, addrs.size()); end else passed++;
        for (int i = 0; i < obs.size() && i < addrs.size(); i++) begin
            total++; if (obs[i] !== words[addrs[i]]) begin
                $display("FAIL bb_read%0d: got %h want %h", i, obs[i], words[addrs[i]]); end else passed++;
        end
    endtask

    task automatic test_random();
        int n, lp, it;
        for (int r = 0; r < 4; r++) begin
            n  = $urandom_range(1, 8);
            lp = $urandom_range(0, 9);
            it = $urandom_range(1, 3);
            gen_model(n, lp, it, CWA, 200);
            do_load(n, lp, it, $urandom_range(0, 60), 1'b0);
            do_run(300, $urandom_range(40, 100), 3, -1);
            total++; if (obs.size() != addrs.size() || done_cnt != 1 || viol != 0) begin
                $display("FAIL rnd%0d_run: reads %0d/%0d done %0d slips %0d", r, obs.size(), addrs.size(), done_cnt, viol);
            end else passed++;
            for (int i = 0; i < obs.size() && i < addrs.size(); i++) begin
                total++; if (obs[i] !== words[addrs[i]]) begin
                    $display("FAIL rnd%0d_read%0d: got %h want %h", r, i, obs[i], words[addrs[i]]); end else passed++;
            end
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; en_pc = 1'b0; available_read = 1'b0;
        num_conf = '0; start_loop = '0; num_iter = '0; rd_data = '0; use_mb = 1'b0;
        test_reset();
        test_single_beat();
        test_multi_beat();
        test_forever();
        test_zero_conf();
        test_reset_midload();
        test_loop_clamp();
        test_full_depth();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
